rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the 12-entry, 16-bit CPU register file between three requesters: ALU writeback, memory-load writeback and the debug/loader port. Round-robin arbitration with a valid/grant handshake; drives the register file's `wre`/`a3`/`wd3` from a registered output stage. Rejects out-of-range register addresses and exposes the in-flight write so read-side logic can forward it.

## Interface
Parameters:
- `DATA_W`, 16, write data width.
- `ADDR_W`, 4, register address width.
- `NUM_REGS`, 12, number of implemented registers; legal addresses are 0..NUM_REGS-1.
- Requester count is fixed at 3; index 0 = ALU, 1 = load, 2 = debug.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  when 1, no grant is issued this cycle.
- `req`  in  3  request valid, one bit per requester.
- `req_addr`  in  3*ADDR_W  requester i's address in bits [4i+3:4i].
- `req_data`  in  3*DATA_W  requester i's data in bits [16i+15:16i].
- `gnt`  out  3  one-hot grant, combinational, at most one bit set.
- `wre`  out  1  register-file write enable (registered).
- `a3`  out  ADDR_W  register-file write address (registered).
- `wd3`  out  DATA_W  register-file write data (registered).
- `err`  out  1  one-cycle pulse: the accepted request had an illegal address.
- `err_id`  out  2  requester index for `err`; valid only while `err`=1.
- `wr_count`  out  16  count of writes issued to the register file.

## Operation
- Handshake: a requester holds `req[i]` with stable addr/data until it sees `gnt[i]`=1. It is accepted at the rising edge where `req[i]`&`gnt[i]`. It may drop `req` or present a new request in the following cycle.
- Priority pointer `ptr` (0..2, reset 0) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2 (mod 3). The first requester found with `req` set is granted.
- `gnt` = 0 whenever `reset`=1, `stall`=1 or `req`=0.
- On acceptance of requester k: `ptr` <= (k+1) mod 3. With no acceptance, `ptr` holds.
- Legal address (< NUM_REGS):
  - Next cycle: `wre`=1, `a3`=addr, `wd3`=data.
  - `wr_count` increments by 1, wrapping 0xFFFF -> 0x0000.
- Illegal address (12..15):
  - The request is still consumed: `gnt` is asserted and `ptr` advances.
  - Next cycle: `wre`=0, `err`=1, `err_id`=k. `wr_count` is unchanged.
- With no acceptance, the next cycle has `wre`=0 and `err`=0. `a3` and `wd3` hold their last values.
- Forwarding: while `wre`=1, the (`a3`, `wd3`) pair is the pending write. Read-side logic compares it against its read addresses.
- States are IDLE (`wre`=0) and WRITE (`wre`=1). The output register re-evaluates every cycle, so back-to-back accepts give `wre`=1 in consecutive cycles.

## Timing
- Reset (synchronous):
  - Registered outputs: `wre`=0, `a3`=0, `wd3`=0, `err`=0, `err_id`=0, `wr_count`=0, `ptr`=0.
  - `gnt`=0 for every cycle that `reset` is high.
- Latency:
  - `gnt` in cycle N.
  - `wre`/`a3`/`wd3` valid in cycle N+1.
  - Register file updated at the end of cycle N+1.
- Throughput: one accepted write per cycle.
- Reset asserted in cycle N+1 after an accept in cycle N: the write is discarded and `wre` is 0 in cycle N+2. Behaviour of the write in N+1 itself follows the registered value present in N+1.
- `stall` affects only grants. A write already registered still issues in the next cycle.
- Requester i drops `req` in the same cycle it would have won: no grant, `ptr` unchanged.
- Simultaneous requests: exactly one grant per cycle. With all three requesting continuously, grants rotate strictly in the order 0,1,2,0,...

## Test plan
- Single write: reset, then `req`=001, addr=5, data=0x1234. Required: `gnt`=001 that cycle; next cycle `wre`=1, `a3`=5, `wd3`=0x1234; `wr_count`=1.
- Round-robin: `req`=111 held for 6 cycles with distinct data. Required: `gnt` sequence 001,010,100,001,010,100; `wre`=1 for 6 consecutive cycles with matching addr/data; `wr_count`=6.
- Illegal address: requester 2 presents addr=13, data=0xBEEF. Required: `gnt`=100; next cycle `wre`=0, `err`=1, `err_id`=2; `wr_count` unchanged; `ptr`=0 afterwards.
- Stall: `req`=010 with `stall`=1 for 3 cycles, then `stall`=0. Required: `gnt`=000 for the 3 stalled cycles, `gnt`=010 on the first unstalled cycle, write issued one cycle later.
- Reset mid-stream: `req`=111 for 2 cycles, then assert `reset` for 1 cycle with `req` still high. Required: `gnt`=000 and `wre`=0 the cycle after reset; first grant after reset goes to requester 0; `wr_count` restarts from 0.
- Counter wrap: preload via 65535 legal writes, then one more. Required: `wr_count` reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Three requesters, registered wre/a3/wd3 stage, illegal-address rejection.
module rf_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [2:0]            req,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            gnt,
    output logic                  wre,
    output logic [ADDR_W-1:0]     a3,
    output logic [DATA_W-1:0]     wd3,
    output logic                  err,
    output logic [1:0]            err_id,
    output logic [15:0]           wr_count
);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [ADDR_W-1:0]   a3_q, a3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;
    logic                err_q, err_d;
    logic [1:0]          err_id_q, err_id_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic                acc;
    logic                legal;
    logic [1:0]          k;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Search order starts at ptr and wraps through the other two.
    always_comb begin
        gnt = 3'b000;
        if (!reset && !stall) begin
            unique case (ptr_q)
                2'd1: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        acc = |gnt;
        k   = 2'd0;
        unique case (1'b1)
            gnt[1]:  k = 2'd1;
            gnt[2]:  k = 2'd2;
            default: k = 2'd0;
        endcase
        sel_addr = req_addr[ADDR_W*k +: ADDR_W];
        sel_data = req_data[DATA_W*k +: DATA_W];
        legal    = ({1'b0, sel_addr} < NREGS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= 2'd0;
            a3_q       <= '0;
            wd3_q      <= '0;
            err_q      <= 1'b0;
            err_id_q   <= 2'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            err_q      <= err_d;
            err_id_q   <= err_id_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = S_IDLE;
        ptr_d      = ptr_q;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        err_d      = 1'b0;
        err_id_d   = err_id_q;
        wr_count_d = wr_count_q;
        if (acc) begin
            ptr_d = (k == 2'd2) ? 2'd0 : k + 2'd1;
            if (legal) begin
                state_d    = S_WRITE;
                a3_d       = sel_addr;
                wd3_d      = sel_data;
                wr_count_d = wr_count_q + 16'd1;
            end else begin
                err_d    = 1'b1;
                err_id_d = k;
            end
        end
    end

    // Outputs
    always_comb begin
        wre      = (state_q == S_WRITE);
        a3       = a3_q;
        wd3      = wd3_q;
        err      = err_q;
        err_id   = err_id_q;
        wr_count = wr_count_q;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter.
// Inputs driven 1ns after posedge; gnt checked 1ns later, registered outputs after the next edge.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  req;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  gnt;
    logic        wre;
    logic [3:0]  a3;
    logic [15:0] wd3;
    logic        err;
    logic [1:0]  err_id;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wre      (wre),
        .a3       (a3),
        .wd3      (wd3),
        .err      (err),
        .err_id   (err_id),
        .wr_count (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [3:0] a0, input logic [3:0] a1,
                            input logic [3:0] a2);
        req_addr = {a2, a1, a0};
    endtask

    task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2);
        req_data = {d2, d1, d0};
    endtask

    logic [2:0]  exp_g;
    logic [15:0] exp_d;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        req   = 3'b111;
        set_addr(4'd1, 4'd2, 4'd3);
        set_data(16'h1111, 16'h2222, 16'h3333);
        #1;
        check("gnt_in_reset", {29'd0, gnt}, 32'h0);
        tick();
        tick();
        check("gnt_in_reset2", {29'd0, gnt}, 32'h0);
        reset = 1'b0;
        req   = 3'b000;
        check("rst_wre", {31'd0, wre}, 32'h0);
        check("rst_a3", {28'd0, a3}, 32'h0);
        check("rst_wd3", {16'd0, wd3}, 32'h0);
        check("rst_err", {31'd0, err}, 32'h0);
        check("rst_err_id", {30'd0, err_id}, 32'h0);
        check("rst_cnt", {16'd0, wr_count}, 32'h0);

        // Single write from ALU
        req = 3'b001;
        set_addr(4'd5, 4'd0, 4'd0);
        set_data(16'h1234, 16'h0, 16'h0);
        #1;
        check("single_gnt", {29'd0, gnt}, 32'h1);
        tick();
        req = 3'b000;
        check("single_wre", {31'd0, wre}, 32'h1);
        check("single_a3", {28'd0, a3}, 32'd5);
        check("single_wd3", {16'd0, wd3}, 32'h1234);
        check("single_cnt", {16'd0, wr_count}, 32'd1);
        tick();
        check("idle_wre", {31'd0, wre}, 32'h0);
        check("idle_a3_hold", {28'd0, a3}, 32'd5);
        check("idle_wd3_hold", {16'd0, wd3}, 32'h1234);

        // Illegal address from debug port (ptr is 1, so 2 wins)
        req = 3'b100;
        set_addr(4'd0, 4'd0, 4'd13);
        set_data(16'h0, 16'h0, 16'hBEEF);
        #1;
        check("ill_gnt", {29'd0, gnt}, 32'h4);
        tick();
        req = 3'b000;
        check("ill_wre", {31'd0, wre}, 32'h0);
        check("ill_err", {31'd0, err}, 32'h1);
        check("ill_err_id", {30'd0, err_id}, 32'd2);
        check("ill_cnt", {16'd0, wr_count}, 32'd1);
        check("ill_a3_hold", {28'd0, a3}, 32'd5);
        tick();
        check("ill_err_pulse", {31'd0, err}, 32'h0);

        // Round-robin, all three requesting; ptr now 0
        req = 3'b111;
        set_addr(4'd1, 4'd2, 4'd3);
        for (int c = 0; c < 6; c++) begin
            exp_g = 3'b001 << (c % 3);
            exp_d = 16'h1000 + 16'(c * 16 + (c % 3));
            set_data(16'h1000 + 16'(c * 16), 16'h1001 + 16'(c * 16),
                     16'h1002 + 16'(c * 16));
            #1;
            check("rr_gnt", {29'd0, gnt}, {29'd0, exp_g});
            tick();
            check("rr_wre", {31'd0, wre}, 32'h1);
            check("rr_a3", {28'd0, a3}, 32'((c % 3) + 1));
            check("rr_wd3", {16'd0, wd3}, {16'd0, exp_d});
        end
        check("rr_cnt", {16'd0, wr_count}, 32'd7);

        // Stall: the last round-robin write is already out; no new grants
        req   = 3'b010;
        stall = 1'b1;
        set_addr(4'd0, 4'd7, 4'd0);
        set_data(16'h0, 16'h7777, 16'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_gnt", {29'd0, gnt}, 32'h0);
            tick();
            check("stall_wre", {31'd0, wre}, 32'h0);
        end
        stall = 1'b0;
        #1;
        check("unstall_gnt", {29'd0, gnt}, 32'h2);
        tick();
        req = 3'b000;
        check("unstall_wre", {31'd0, wre}, 32'h1);
        check("unstall_a3", {28'd0, a3}, 32'd7);
        check("unstall_wd3", {16'd0, wd3}, 32'h7777);
        check("unstall_cnt", {16'd0, wr_count}, 32'd8);

        // Dropped request: ptr stays at 2
        #1;
        check("drop_gnt", {29'd0, gnt}, 32'h0);
        tick();
        req = 3'b111;
        set_addr(4'd1, 4'd2, 4'd3);
        set_data(16'hA0A0, 16'hA1A1, 16'hA2A2);
        #1;
        check("drop_ptr_gnt", {29'd0, gnt}, 32'h4);
        tick();
        req = 3'b000;
        check("drop_wd3", {16'd0, wd3}, 32'hA2A2);
        check("drop_cnt", {16'd0, wr_count}, 32'd9);

        // Address boundary: 11 legal, 12 illegal; ptr now 0
        req = 3'b010;
        set_addr(4'd0, 4'd11, 4'd0);
        set_data(16'h0, 16'h0B0B, 16'h0);
        #1;
        check("b11_gnt", {29'd0, gnt}, 32'h2);
        tick();
        check("b11_wre", {31'd0, wre}, 32'h1);
        check("b11_a3", {28'd0, a3}, 32'd11);
        check("b11_cnt", {16'd0, wr_count}, 32'd10);
        req = 3'b001;
        set_addr(4'd12, 4'd0, 4'd0);
        set_data(16'hC0C0, 16'h0, 16'h0);
        #1;
        check("b12_gnt", {29'd0, gnt}, 32'h1);
        tick();
        req = 3'b000;
        check("b12_wre", {31'd0, wre}, 32'h0);
        check("b12_err", {31'd0, err}, 32'h1);
        check("b12_err_id", {30'd0, err_id}, 32'd0);
        check("b12_cnt", {16'd0, wr_count}, 32'd10);

        // Reset mid-stream; ptr is 1 going in
        req = 3'b111;
        set_addr(4'd1, 4'd2, 4'd3);
        set_data(16'hD0D0, 16'hD1D1, 16'hD2D2);
        #1;
        check("mid_gnt_a", {29'd0, gnt}, 32'h2);
        tick();
        #1;
        check("mid_gnt_b", {29'd0, gnt}, 32'h4);
        tick();
        reset = 1'b1;
        #1;
        check("mid_gnt_rst", {29'd0, gnt}, 32'h0);
        check("mid_wre_rst", {31'd0, wre}, 32'h1);
        check("mid_wd3_rst", {16'd0, wd3}, 32'hD2D2);
        check("mid_cnt_rst", {16'd0, wr_count}, 32'd12);
        tick();
        reset = 1'b0;
        check("post_rst_wre", {31'd0, wre}, 32'h0);
        check("post_rst_cnt", {16'd0, wr_count}, 32'd0);
        #1;
        check("post_rst_gnt", {29'd0, gnt}, 32'h1);
        tick();
        check("post_rst_cnt1", {16'd0, wr_count}, 32'd1);
        check("post_rst_wd3", {16'd0, wd3}, 32'hD0D0);

        // Counter wrap
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req   = 3'b001;
        set_addr(4'd4, 4'd0, 4'd0);
        set_data(16'h4444, 16'h0, 16'h0);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_ffff", {16'd0, wr_count}, 32'hFFFF);
        tick();
        req = 3'b000;
        check("wrap_zero", {16'd0, wr_count}, 32'h0);
        check("wrap_wre", {31'd0, wre}, 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
